// File: rtl/vec_write_seq.sv
// Vector register file write sequencer: serialises full-vector writes into one
// lane per cycle with a fetch stall, and passes single-element writes straight through.
module vec_write_seq #(
    parameter int unsigned LANES = 4,
    parameter int unsigned IDXW  = 2,
    parameter int unsigned EW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  VecWrite,
    input  logic                  VecIdxWrite,
    input  logic [3:0]            VecRd,
    input  logic [IDXW-1:0]       VecIdx,
    input  logic [LANES*EW-1:0]   VecData,
    input  logic [EW-1:0]         ScalarData,
    output logic                  Stall,
    output logic                  VrfWE,
    output logic [3:0]            VrfAddr,
    output logic [IDXW-1:0]       VrfLane,
    output logic [EW-1:0]         VrfWD,
    output logic                  Done
);

    localparam int unsigned VW = LANES * EW;
    localparam logic [IDXW-1:0] LAST_LANE = IDXW'(LANES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state, stateNext;
    logic [IDXW-1:0] cnt, cntNext;
    logic [VW-1:0]   vbuf, vbufNext;
    logic [3:0]      rbuf, rbufNext;

    // State and latched-operand registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            vbuf  <= '0;
            rbuf  <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            vbuf  <= vbufNext;
            rbuf  <= rbufNext;
        end
    end

    // Next-state and write-port drive; everything reads as zero while in reset
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        vbufNext  = vbuf;
        rbufNext  = rbuf;
        Stall     = 1'b0;
        VrfWE     = 1'b0;
        VrfAddr   = '0;
        VrfLane   = '0;
        VrfWD     = '0;
        Done      = 1'b0;

        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (VecWrite) begin
                        // Accept cycle: latch operands, hold fetch, no write yet
                        Stall     = 1'b1;
                        vbufNext  = VecData;
                        rbufNext  = VecRd;
                        cntNext   = '0;
                        stateNext = WRITE;
                    end else if (VecIdxWrite) begin
                        VrfWE   = 1'b1;
                        VrfAddr = VecRd;
                        VrfLane = VecIdx;
                        VrfWD   = ScalarData;
                    end
                end
                WRITE: begin
                    VrfWE   = 1'b1;
                    VrfAddr = rbuf;
                    VrfLane = cnt;
                    VrfWD   = vbuf[int'(cnt)*EW +: EW];
                    cntNext = cnt + IDXW'(1);
                    if (cnt == LAST_LANE) begin
                        // Final lane: release the PC this edge
                        Done      = 1'b1;
                        cntNext   = '0;
                        stateNext = IDLE;
                    end else begin
                        Stall = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_write_seq.sv
// Directed bench for vec_write_seq: expected register-file writes are queued by
// the stimulus and checked by an independent monitor; stall/done checked per cycle.
module tb_vec_write_seq;

    localparam int unsigned LANES = 4;
    localparam int unsigned IDXW  = 2;
    localparam int unsigned EW    = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  VecWrite;
    logic                  VecIdxWrite;
    logic [3:0]            VecRd;
    logic [IDXW-1:0]       VecIdx;
    logic [LANES*EW-1:0]   VecData;
    logic [EW-1:0]         ScalarData;
    logic                  Stall;
    logic                  VrfWE;
    logic [3:0]            VrfAddr;
    logic [IDXW-1:0]       VrfLane;
    logic [EW-1:0]         VrfWD;
    logic                  Done;

    vec_write_seq #(.LANES(LANES), .IDXW(IDXW), .EW(EW)) dut (
        .clk        (clk),
        .reset      (reset),
        .VecWrite   (VecWrite),
        .VecIdxWrite(VecIdxWrite),
        .VecRd      (VecRd),
        .VecIdx     (VecIdx),
        .VecData    (VecData),
        .ScalarData (ScalarData),
        .Stall      (Stall),
        .VrfWE      (VrfWE),
        .VrfAddr    (VrfAddr),
        .VrfLane    (VrfLane),
        .VrfWD      (VrfWD),
        .Done       (Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      addr;
        logic [IDXW-1:0] lane;
        logic [EW-1:0]   wd;
    } wr_t;

    wr_t expQ[$];
    int  nChecks = 0;
    int  nFail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic pushWrite(input logic [3:0] a, input logic [IDXW-1:0] l, input logic [EW-1:0] d);
        wr_t w;
        w.addr = a;
        w.lane = l;
        w.wd   = d;
        expQ.push_back(w);
    endtask

    task automatic pushVec(input logic [3:0] a, input logic [EW-1:0] l0, input logic [EW-1:0] l1,
                           input logic [EW-1:0] l2, input logic [EW-1:0] l3);
        pushWrite(a, 2'd0, l0);
        pushWrite(a, 2'd1, l1);
        pushWrite(a, 2'd2, l2);
        pushWrite(a, 2'd3, l3);
    endtask

    // Check control outputs mid-cycle, then advance to just after the next edge
    task automatic step(input string name, input logic expStall, input logic expDone, input logic expWe);
        @(negedge clk);
        chk({name, ".Stall"}, 32'(Stall), 32'(expStall));
        chk({name, ".Done"},  32'(Done),  32'(expDone));
        chk({name, ".VrfWE"}, 32'(VrfWE), 32'(expWe));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented write must match the oldest expected one
    always @(negedge clk) begin
        if (VrfWE === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_write: got addr=%0d lane=%0d wd=0x%0h expected none at %0t",
                         VrfAddr, VrfLane, VrfWD, $time);
            end else begin
                wr_t w;
                w = expQ.pop_front();
                chk("write.addr", 32'(VrfAddr), 32'(w.addr));
                chk("write.lane", 32'(VrfLane), 32'(w.lane));
                chk("write.wd",   32'(VrfWD),   32'(w.wd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        VecWrite    = 1'b1;
        VecIdxWrite = 1'b0;
        VecRd       = 4'd5;
        VecIdx      = '0;
        VecData     = {32'h44, 32'h33, 32'h22, 32'h11};
        ScalarData  = '0;

        // Reset held with VecWrite asserted: all outputs quiet
        @(posedge clk);
        #1;
        step("rst0", 1'b0, 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Full vector to v5, strobe held for the whole sequence
        pushVec(4'd5, 32'h11, 32'h22, 32'h33, 32'h44);
        step("vec.accept", 1'b1, 1'b0, 1'b0);
        step("vec.lane0",  1'b1, 1'b0, 1'b1);
        step("vec.lane1",  1'b1, 1'b0, 1'b1);
        step("vec.lane2",  1'b1, 1'b0, 1'b1);
        VecWrite = 1'b0;
        step("vec.lane3",  1'b0, 1'b1, 1'b1);
        step("vec.idle",   1'b0, 1'b0, 1'b0);

        // Indexed write: same-cycle, no stall
        VecIdxWrite = 1'b1;
        VecRd       = 4'd2;
        VecIdx      = 2'd3;
        ScalarData  = 32'hDEADBEEF;
        pushWrite(4'd2, 2'd3, 32'hDEADBEEF);
        step("idx.write", 1'b0, 1'b0, 1'b1);
        VecIdxWrite = 1'b0;
        step("idx.after", 1'b0, 1'b0, 1'b0);

        // Both strobes: full-vector wins, no indexed write
        VecWrite    = 1'b1;
        VecIdxWrite = 1'b1;
        VecRd       = 4'd7;
        VecIdx      = 2'd1;
        ScalarData  = 32'hBAD0BAD0;
        VecData     = {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1};
        pushVec(4'd7, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4);
        step("pri.accept", 1'b1, 1'b0, 1'b0);
        VecWrite    = 1'b0;
        VecIdxWrite = 1'b0;
        step("pri.lane0",  1'b1, 1'b0, 1'b1);
        step("pri.lane1",  1'b1, 1'b0, 1'b1);
        step("pri.lane2",  1'b1, 1'b0, 1'b1);
        step("pri.lane3",  1'b0, 1'b1, 1'b1);

        // Inputs change during WRITE, then back-to-back restart with new operands
        VecWrite = 1'b1;
        VecRd    = 4'd9;
        VecData  = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
        pushVec(4'd9, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D);
        step("chg.accept", 1'b1, 1'b0, 1'b0);
        VecData = {LANES*EW{1'b1}};
        VecRd   = 4'd3;
        step("chg.lane0",  1'b1, 1'b0, 1'b1);
        VecIdxWrite = 1'b1;
        step("chg.lane1",  1'b1, 1'b0, 1'b1);
        VecIdxWrite = 1'b0;
        step("chg.lane2",  1'b1, 1'b0, 1'b1);
        step("chg.lane3",  1'b0, 1'b1, 1'b1);
        pushVec(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step("b2b.accept", 1'b1, 1'b0, 1'b0);
        VecWrite = 1'b0;
        step("b2b.lane0",  1'b1, 1'b0, 1'b1);
        step("b2b.lane1",  1'b1, 1'b0, 1'b1);
        step("b2b.lane2",  1'b1, 1'b0, 1'b1);
        step("b2b.lane3",  1'b0, 1'b1, 1'b1);

        // Reset after lane 1: lanes 2 and 3 must never appear
        VecWrite = 1'b1;
        VecRd    = 4'd6;
        VecData  = {32'h4, 32'h3, 32'h2, 32'h1};
        pushWrite(4'd6, 2'd0, 32'h1);
        pushWrite(4'd6, 2'd1, 32'h2);
        step("rmid.accept", 1'b1, 1'b0, 1'b0);
        VecWrite = 1'b0;
        step("rmid.lane0",  1'b1, 1'b0, 1'b1);
        step("rmid.lane1",  1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        step("rmid.rst0",   1'b0, 1'b0, 1'b0);
        step("rmid.rst1",   1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step("rmid.idle",   1'b0, 1'b0, 1'b0);
        step("rmid.idle2",  1'b0, 1'b0, 1'b0);

        // Back in IDLE: an indexed write goes straight through
        VecIdxWrite = 1'b1;
        VecRd       = 4'd15;
        VecIdx      = 2'd0;
        ScalarData  = 32'h12345678;
        pushWrite(4'd15, 2'd0, 32'h12345678);
        step("post.idx", 1'b0, 1'b0, 1'b1);
        VecIdxWrite = 1'b0;
        step("post.idle", 1'b0, 1'b0, 1'b0);

        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
